// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the
// single-port memory command/response signals.
// slave  : the arbiter's view.
// master : the environment's view (datapath requesters plus memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch (IF) port
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_kill;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;
  logic                  if_stall;
  // data (DM) port
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ready;
  logic                  dm_stall;
  // memory side
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  // status
  logic                  busy;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ready, if_stall,
    output dm_rdata, dm_ready, dm_stall,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_kill,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ready, if_stall,
    input  dm_rdata, dm_ready, dm_stall,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// (IF) and the memory stage (DM). One transaction at a time runs through
// IDLE -> CMD -> WAIT -> RESP; a fixed-latency counter times the read data.
// DM has priority, except that IF wins right after a DM grant, so fetch
// cannot starve under continuous contention.
// Optional feature macro: ARB_PERF_CNT_EN adds saturating perf counters
// perf_conflict (IDLE cycles with both requests high) and perf_if_wait
// (cycles with if_stall high).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_if_wait
`endif
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                win_dm;
  logic                last_dm;
  logic                kill;
  logic                cmd_we;
  logic [BE_W-1:0]     cmd_be;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W-1:0]   resp_data;

  logic                any_req;
  logic                grant_dm;
  logic                grant_now;
  logic                mem_en;
  logic                if_ready;
  logic                dm_ready;
  logic                busy;
  logic                if_stall;

  assign any_req   = bus.if_req | bus.dm_req;
  // DM wins a tie unless DM had the previous grant and fetch is waiting.
  assign grant_dm  = bus.dm_req & ~(last_dm & bus.if_req);
  assign grant_now = (state == IDLE) & any_req;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one transaction per pass, no re-sampling in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CMD;
      CMD:     state_nxt = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes come from the state, ready only for the winner.
  always_comb begin
    mem_en   = 1'b0;
    if_ready = 1'b0;
    dm_ready = 1'b0;
    busy     = (state != IDLE);
    case (state)
      CMD:  mem_en = 1'b1;
      RESP: begin
        // A kill arriving in the RESP cycle itself still suppresses the pulse.
        if_ready = ~win_dm & ~kill & ~bus.if_kill;
        dm_ready = win_dm;
      end
      default: ;
    endcase
  end

  // Command capture and arbitration history, latched on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_dm    <= 1'b0;
      last_dm   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant_now) begin
      win_dm    <= grant_dm;
      last_dm   <= grant_dm;
      cmd_we    <= grant_dm & bus.dm_we;
      cmd_be    <= grant_dm ? bus.dm_be    : '1;
      cmd_addr  <= grant_dm ? bus.dm_addr  : bus.if_addr;
      cmd_wdata <= grant_dm ? bus.dm_wdata : '0;
    end
  end

  // Kill flag: remembers a fetch cancel until the transaction retires.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == RESP) kill <= 1'b0;
    else if (!win_dm && bus.if_kill)           kill <= 1'b1;
  end

  // Latency counter and read-data capture on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      resp_data <= '0;
    end else begin
      if (state == CMD)       cnt <= CNT_W'(MEM_LATENCY);
      else if (state == WAIT) cnt <= cnt - CNT_W'(1);
      if (state == WAIT && cnt == CNT_W'(1)) resp_data <= bus.mem_rdata;
    end
  end

  assign if_stall      = bus.if_req & ~if_ready;

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_be    = cmd_be;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_ready  = if_ready;
  assign bus.dm_ready  = dm_ready;
  assign bus.if_rdata  = resp_data;
  assign bus.dm_rdata  = resp_data;
  assign bus.if_stall  = if_stall;
  assign bus.dm_stall  = bus.dm_req & ~dm_ready;
  assign bus.busy      = busy;

`ifdef ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= '0;
      perf_if_wait  <= '0;
    end else begin
      if (state == IDLE && bus.if_req && bus.dm_req) perf_conflict <= sat_inc(perf_conflict);
      if (if_stall) perf_if_wait <= sat_inc(perf_if_wait);
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_if_wait;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_if_wait(perf_if_wait)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int E      = 0;

  // reference model: one outstanding transaction, granted at edge m_g
  bit          m_act, m_dm, m_kill, m_last_dm, m_we;
  int          m_g;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  // memory model state and observation counters
  bit          pend_v;
  int          pend_e;
  logic [31:0] pend_addr;
  int          obs_ifr, obs_dmr, obs_en;
  bit          obs_q[$];
  bit          if_done, dm_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, E, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Advance one clock edge and update the model with the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
    E++;
    if (rst) begin
      m_act = 1'b0; m_last_dm = 1'b0; m_kill = 1'b0;
    end else if (!m_act) begin
      if (bus.if_req || bus.dm_req) begin
        m_dm      = bus.dm_req && !(m_last_dm && bus.if_req);
        m_last_dm = m_dm;
        m_act     = 1'b1;
        m_g       = E;
        m_kill    = 1'b0;
        m_we      = m_dm && bus.dm_we;
        m_be      = m_dm ? bus.dm_be : 4'hF;
        m_addr    = m_dm ? bus.dm_addr : bus.if_addr;
        m_wdata   = bus.dm_wdata;
      end
    end else if (E == m_g + ML + 2) begin
      m_act = 1'b0;
    end
    if (if_done) begin bus.if_req = 1'b0; if_done = 1'b0; end
    if (dm_done) begin bus.dm_req = 1'b0; dm_done = 1'b0; end
    bus.mem_rdata = (pend_v && E == pend_e + ML) ? memfn(pend_addr) : $urandom;
  endtask

  // Compare all outputs mid-cycle, after this cycle's inputs are applied.
  task automatic check_cycle();
    bit exp_en, resp, exp_ifr, exp_dmr;
    @(negedge clk);
    exp_en  = m_act && (E == m_g);
    resp    = m_act && (E == m_g + ML + 1);
    exp_ifr = resp && !m_dm && !m_kill && !bus.if_kill;
    exp_dmr = resp && m_dm;
    if (m_act && !m_dm && bus.if_kill) m_kill = 1'b1;
    chk("busy", bus.busy, m_act);
    chk("mem_en", bus.mem_en, exp_en);
    if (exp_en) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_be", bus.mem_be, m_be);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("if_ready", bus.if_ready, exp_ifr);
    chk("dm_ready", bus.dm_ready, exp_dmr);
    if (exp_ifr) chk("if_rdata", bus.if_rdata, memfn(m_addr));
    if (exp_dmr && !m_we) chk("dm_rdata", bus.dm_rdata, memfn(m_addr));
    chk("if_stall", bus.if_stall, bus.if_req & ~exp_ifr);
    chk("dm_stall", bus.dm_stall, bus.dm_req & ~exp_dmr);
    if (bus.mem_en === 1'b1) begin
      pend_v = 1'b1; pend_e = E; pend_addr = bus.mem_addr;
      obs_en++;
      obs_q.push_back(bus.mem_addr >= 32'h2000);
    end
    if (bus.if_ready === 1'b1) obs_ifr++;
    if (bus.dm_ready === 1'b1) obs_dmr++;
    if (exp_ifr) if_done = 1'b1;
    if (exp_dmr) dm_done = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin tick(); check_cycle(); end
  endtask

  task automatic reset_checks();
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_if_stall", bus.if_stall, bus.if_req);
    chk("rst_dm_stall", bus.dm_stall, bus.dm_req);
  endtask

  task automatic rand_drive();
    bus.if_kill = 1'b0;
    if ($urandom_range(0, 19) == 0) begin
      bus.if_kill = 1'b1;
      bus.if_req  = 1'b0;
    end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_be    = 4'($urandom);
      bus.dm_addr  = $urandom & 32'hFFFF_FFFC;
      bus.dm_wdata = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0, d0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;

    // reset state, stall follows req while in reset
    tick(); check_cycle(); reset_checks();
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h100; check_cycle(); reset_checks();
    tick(); bus.if_req = 1'b0; rst = 1'b0; check_cycle(); reset_checks();

    // single fetch at 0x100
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h100; check_cycle();
    run(8);

    // simultaneous DM load and fetch: DM first, then IF
    tick();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    check_cycle();
    run(12);

    // continuous contention: grants must alternate starting with DM
    obs_q.delete();
    for (int k = 0; k < 24; k++) begin
      tick();
      if (!bus.dm_req) begin
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000 + 32'(16 * k);
      end
      if (!bus.if_req) begin
        bus.if_req = 1'b1; bus.if_addr = 32'h100 + 32'(4 * k);
      end
      check_cycle();
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    run(8);
    chk("grant_cnt_ge4", 32'(obs_q.size() >= 4), 1);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk("grant_order", 32'(obs_q[i]), 32'((i % 2) == 0));

    // partial store
    d0 = obs_dmr; e0 = obs_en;
    tick();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_addr = 32'h40; bus.dm_wdata = 32'h1234_5678;
    check_cycle();
    run(7);
    chk("store_ready_cnt", 32'(obs_dmr - d0), 1);
    chk("store_en_cnt", 32'(obs_en - e0), 1);
    bus.dm_we = 1'b0;

    // fetch killed during WAIT
    a0 = obs_ifr; e0 = obs_en;
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h180; check_cycle();
    tick(); check_cycle();
    tick(); bus.if_kill = 1'b1; bus.if_req = 1'b0; check_cycle();
    tick(); bus.if_kill = 1'b0; check_cycle();
    run(4);
    chk("kill_ready_cnt", 32'(obs_ifr - a0), 0);
    chk("kill_en_cnt", 32'(obs_en - e0), 1);
    chk("kill_busy_after", bus.busy, 0);
    a0 = obs_ifr;
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h184; check_cycle();
    run(7);
    chk("refetch_ready_cnt", 32'(obs_ifr - a0), 1);

    // reset during WAIT of a DM load, then held request is re-granted
    d0 = obs_dmr;
    tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000; check_cycle();
    tick(); check_cycle();
    tick(); rst = 1'b1; check_cycle();
    tick(); rst = 1'b0; check_cycle(); reset_checks();
    run(8);
    chk("rst_abort_ready_cnt", 32'(obs_dmr - d0), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(); rand_drive(); check_cycle();
    end
    tick(); bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.if_kill = 1'b0; check_cycle();
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
